// File: rtl/fetch_unit.sv
// fetch_unit -- MIPS instruction-fetch stage.
//
// Holds the PC, reads one instruction word at a time from instruction memory
// over a req/ack handshake, presents it on inst to the decoder, and computes
// the next PC from the jump/branch/zero results returned for that instruction.
// Counts retired instructions.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   imemReq     fetch request to instruction memory
//   imemAddr    word-aligned byte address being fetched
//   imemAck     memory data valid on imemData this cycle
//   imemData    instruction word from memory
//   inst        instruction register (to decoder)
//   instValid   inst is live in execute
//   pc          address of inst
//   branch      decoder: inst is beq
//   jump        decoder: inst is j
//   zero        ALU zero flag for inst
//   stall       hold the current instruction in execute
//   instrCount  retired-instruction counter, wraps mod 2^32
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] inst,
  output logic        instValid,
  output logic [31:0] pc,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic        stall,
  output logic [31:0] instrCount
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  typedef enum logic {
    ST_FETCH,
    ST_EXEC
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_count;
  logic        r_valid;

  logic        w_capture;
  logic        w_retire;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_next_pc;

  // Next-state and handshake decode
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (imemAck) begin
          w_capture    = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          w_retire     = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      default: w_state_next = ST_FETCH;
    endcase
  end

  // Next-PC selection; jump takes priority over a taken branch
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_offset = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump) begin
      w_next_pc = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};
    end else if (branch && zero) begin
      w_next_pc = w_pc_plus4 + w_br_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_pc    <= PC_INIT;
      r_inst  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_inst  <= imemData;
        r_valid <= 1'b1;
      end
      if (w_retire) begin
        r_pc    <= w_next_pc;
        r_count <= r_count + 32'd1;
        r_valid <= 1'b0;
      end
    end
  end

  // Request is gated by rst_n so memory sees no request during a reset cycle,
  // even when reset lands while a fetch is outstanding.
  assign imemReq    = rst_n && (r_state == ST_FETCH);
  assign imemAddr   = r_pc;
  assign inst       = r_inst;
  assign instValid  = r_valid;
  assign pc         = r_pc;
  assign instrCount = r_count;

endmodule
